// File: rtl/sand_cell_updater.sv
// +--------------------------------------------------------------------------+
// | sand_cell_updater: moves one sand cell down / diagonally via probe FSM.   |
// | Option: SAND_CELL_RANDOM_BIAS_EN selects LFSR diagonal bias. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sand_cell_updater #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int COL_WIDTH      = $clog2(ACTIVE_COLUMNS),
  parameter int DATA_WIDTH     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ready_i,
  input  logic [ADDR_WIDTH-1:0] base_address_i,
  input  logic [COL_WIDTH-1:0]  col_i,
  input  logic [DATA_WIDTH-1:0] pixel_state_i,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  wr_ena_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  moved_o
);

  localparam logic [ADDR_WIDTH-1:0] c_row_stride   = ADDR_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] c_bottom_start = ADDR_WIDTH'((ACTIVE_ROWS-1)*ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] c_one          = ADDR_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0]  c_col_max      = COL_WIDTH'(ACTIVE_COLUMNS-1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PROBE_DOWN = 4'd1,
    CHECK_DOWN = 4'd2,
    PROBE_D1   = 4'd3,
    CHECK_D1   = 4'd4,
    PROBE_D2   = 4'd5,
    CHECK_D2   = 4'd6,
    WRITE_DST  = 4'd7,
    CLEAR_SRC  = 4'd8,
    DONE       = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [DATA_WIDTH-1:0] mat_q, mat_d;
  logic                  dir_q, dir_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [ADDR_WIDTH-1:0] read_address_q, read_address_d;
  logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  wr_ena_q, wr_ena_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  moved_q, moved_d;
  logic                  advance;
  logic                  bias;

  // Geometry of the cell being worked on; in IDLE it is the incoming request.
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [COL_WIDTH-1:0]  cur_col;
  logic                  cur_dir;
  logic [ADDR_WIDTH-1:0] down_a, left_a, right_a, d1_a, d2_a;
  logic                  left_ok, right_ok, d1_ok, d2_ok;

  always_comb begin
    cur_base = (state_q == IDLE) ? base_address_i : base_q;
    cur_col  = (state_q == IDLE) ? col_i : col_q;
    cur_dir  = (state_q == IDLE) ? bias : dir_q;
    down_a   = cur_base + c_row_stride;
    left_a   = cur_base + c_row_stride - c_one;
    right_a  = cur_base + c_row_stride + c_one;
    left_ok  = (cur_col != '0);
    right_ok = (cur_col != c_col_max);
    d1_a     = cur_dir ? right_a : left_a;
    d2_a     = cur_dir ? left_a : right_a;
    d1_ok    = cur_dir ? right_ok : left_ok;
    d2_ok    = cur_dir ? left_ok : right_ok;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    col_d    = col_q;
    mat_d    = mat_q;
    dir_d    = dir_q;
    target_d = target_q;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_i) begin
          base_d = base_address_i;
          col_d  = col_i;
          mat_d  = pixel_state_i;
          dir_d  = bias;
          if (pixel_state_i == '0 || base_address_i >= c_bottom_start) begin
            state_d = DONE;
          end else begin
            state_d = PROBE_DOWN;
            advance = 1'b1;
          end
        end
      end
      PROBE_DOWN: state_d = CHECK_DOWN;
      CHECK_DOWN: begin
        if (pixel_state_i == '0) begin
          target_d = down_a;
          state_d  = WRITE_DST;
        end else if (d1_ok) begin
          state_d = PROBE_D1;
        end else if (d2_ok) begin
          state_d = PROBE_D2;
        end else begin
          state_d = DONE;
        end
      end
      PROBE_D1: state_d = CHECK_D1;
      CHECK_D1: begin
        if (pixel_state_i == '0) begin
          target_d = d1_a;
          state_d  = WRITE_DST;
        end else if (d2_ok) begin
          state_d = PROBE_D2;
        end else begin
          state_d = DONE;
        end
      end
      PROBE_D2: state_d = CHECK_D2;
      CHECK_D2: begin
        if (pixel_state_i == '0) begin
          target_d = d2_a;
          state_d  = WRITE_DST;
        end else begin
          state_d = DONE;
        end
      end
      WRITE_DST: state_d = CLEAR_SRC;
      CLEAR_SRC: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      PROBE_DOWN: read_address_d = down_a;
      PROBE_D1:   read_address_d = d1_a;
      PROBE_D2:   read_address_d = d2_a;
      default:    read_address_d = '0;
    endcase
    wr_ena_d        = (state_d == WRITE_DST) || (state_d == CLEAR_SRC);
    write_address_d = (state_d == WRITE_DST) ? target_d :
                      (state_d == CLEAR_SRC) ? base_q : '0;
    write_data_d    = (state_d == WRITE_DST) ? mat_q : '0;
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
    moved_d         = (state_d == DONE) && (state_q == CLEAR_SRC);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      base_q          <= '0;
      col_q           <= '0;
      mat_q           <= '0;
      dir_q           <= 1'b0;
      target_q        <= '0;
      read_address_q  <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      wr_ena_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      moved_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      col_q           <= col_d;
      mat_q           <= mat_d;
      dir_q           <= dir_d;
      target_q        <= target_d;
      read_address_q  <= read_address_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      wr_ena_q        <= wr_ena_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      moved_q         <= moved_d;
    end
  end

`ifdef SAND_CELL_RANDOM_BIAS_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bias = lfsr_q[0];
`else
  logic bias_q, bias_d;

  always_comb begin
    bias_d = bias_q ^ advance;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bias_q <= 1'b0;
    end else begin
      bias_q <= bias_d;
    end
  end

  assign bias = bias_q;
`endif

  assign read_address_o  = read_address_q;
  assign write_address_o = write_address_q;
  assign write_data_o    = write_data_q;
  assign wr_ena_o        = wr_ena_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign moved_o         = moved_q;

endmodule

`default_nettype wire

// File: tb/tb_sand_cell_updater.sv
// Bench for sand_cell_updater on an 8x4 grid with a registered-read memory model.
`default_nettype none

module tb_sand_cell_updater;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int DW   = 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          ready_i = 1'b0;
  logic [AW-1:0] base_address_i = '0;
  logic [CW-1:0] col_i = '0;
  logic [DW-1:0] pixel_state_i;
  logic [AW-1:0] read_address_o;
  logic [AW-1:0] write_address_o;
  logic [DW-1:0] write_data_o;
  logic          wr_ena_o;
  logic          busy_o;
  logic          done_o;
  logic          moved_o;

  logic [DW-1:0] mem [COLS*ROWS];
  logic [DW-1:0] rd_q = '0;
  logic          drive_base = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            bias_m = 1'b0;

  sand_cell_updater #(
    .ACTIVE_COLUMNS(COLS),
    .ACTIVE_ROWS   (ROWS),
    .ADDR_WIDTH    (AW),
    .COL_WIDTH     (CW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .ready_i        (ready_i),
    .base_address_i (base_address_i),
    .col_i          (col_i),
    .pixel_state_i  (pixel_state_i),
    .read_address_o (read_address_o),
    .write_address_o(write_address_o),
    .write_data_o   (write_data_o),
    .wr_ena_o       (wr_ena_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .moved_o        (moved_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) rd_q <= mem[read_address_o];

  assign pixel_state_i = drive_base ? mem[base_address_i] : rd_q;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference: candidate list in probe order, first empty one wins.
  task automatic model(input int b, input int c, input bit bi,
                       output int done_cyc, output bit mv, output int tgt,
                       output int wcyc, output bit accepted);
    int cands[$];
    int left, right;
    mv = 0; tgt = 0; wcyc = 0; accepted = 0;
    if (mem[b] == 0 || b >= (ROWS-1)*COLS) begin
      done_cyc = 1;
      return;
    end
    accepted = 1;
    left  = (b + COLS - 1) % (COLS*ROWS);
    right = (b + COLS + 1) % (COLS*ROWS);
    cands.push_back((b + COLS) % (COLS*ROWS));
    if (!bi) begin
      if (c != 0)      cands.push_back(left);
      if (c != COLS-1) cands.push_back(right);
    end else begin
      if (c != COLS-1) cands.push_back(right);
      if (c != 0)      cands.push_back(left);
    end
    done_cyc = 1 + 2*cands.size();
    foreach (cands[k]) begin
      if (mem[cands[k]] == 0) begin
        mv = 1; tgt = cands[k]; wcyc = 3 + 2*k; done_cyc = 5 + 2*k;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    reset_i = 1'b0;
    bias_m  = 1'b0;
  endtask

  // Issues one request at a sample point (#1 after an edge) and checks the whole update.
  task automatic run_cell(input int b, input bit noisy);
    int  exp_done, exp_tgt, exp_wcyc;
    bit  exp_mv, acc;
    int  mat, cyc, nw, got_done, not_busy;
    int  wc[2], wa[2], wd[2];
    int  c;
    c = b % COLS;
    model(b, c, bias_m, exp_done, exp_mv, exp_tgt, exp_wcyc, acc);
    mat = int'(mem[b]);
    if (acc) bias_m = ~bias_m;
    ready_i = 1'b1; base_address_i = AW'(b); col_i = CW'(c); drive_base = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0; drive_base = 1'b0;
    nw = 0; got_done = 0; not_busy = 0;
    wc = '{0, 0}; wa = '{0, 0}; wd = '{0, 0};
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (!busy_o) not_busy++;
      if (wr_ena_o) begin
        if (nw < 2) begin
          wc[nw] = cyc; wa[nw] = int'(write_address_o); wd[nw] = int'(write_data_o);
        end
        nw++;
        mem[write_address_o] = write_data_o;
      end
      if (done_o) begin
        got_done = cyc;
        check("moved", int'(moved_o), int'(exp_mv));
        break;
      end
      if (noisy) begin
        ready_i = 1'($urandom_range(0, 1));
        base_address_i = AW'($urandom_range(0, COLS*ROWS-1));
      end
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0;
    check("done_cycle", got_done, exp_done);
    check("busy_gap", not_busy, 0);
    check("write_count", nw, exp_mv ? 2 : 0);
    if (exp_mv) begin
      check("dst_cycle", wc[0], exp_wcyc);
      check("dst_addr", wa[0], exp_tgt);
      check("dst_data", wd[0], mat);
      check("clr_cycle", wc[1], exp_wcyc + 1);
      check("clr_addr", wa[1], b);
      check("clr_data", wd[1], 0);
    end
    @(posedge clk_i); #1;
    check("idle_after_done", int'({busy_o, done_o}), 0);
  endtask

  initial begin
    int b;
    foreach (mem[i]) mem[i] = '0;
    do_reset();
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_wr_ena", int'(wr_ena_o), 0);
    check("rst_moved", int'(moved_o), 0);

    // Empty cell: no-op.
    mem[10] = 2'd0;
    run_cell(10, 1'b0);
    // Straight down move.
    mem[10] = 2'd1; mem[18] = 2'd0;
    run_cell(10, 1'b0);
    check("down_dst", int'(mem[18]), 1);
    check("down_src", int'(mem[10]), 0);
    // Left edge: only the right diagonal can be probed.
    mem[8] = 2'd1; mem[16] = 2'd1; mem[17] = 2'd1;
    run_cell(8, 1'b0);
    check("edge_src", int'(mem[8]), 1);
    // Bias back at 0: left diagonal first.
    mem[10] = 2'd2; mem[18] = 2'd1; mem[17] = 2'd0; mem[19] = 2'd0;
    run_cell(10, 1'b0);
    check("diag_dst", int'(mem[17]), 2);
    check("diag_src", int'(mem[10]), 0);
    check("diag_right_untouched", int'(mem[19]), 0);
    // Bottom row.
    mem[26] = 2'd1;
    run_cell(26, 1'b0);

    // Reset in WRITE_DST aborts the clear.
    mem[3] = 2'd3; mem[11] = 2'd0;
    ready_i = 1'b1; base_address_i = AW'(3); col_i = CW'(3); drive_base = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0; drive_base = 1'b0;
    repeat (2) begin @(posedge clk_i); #1; end
    check("abort_pre_wr", int'(wr_ena_o), 1);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_wr_ena", int'(wr_ena_o), 0);
    check("abort_busy", int'(busy_o), 0);
    reset_i = 1'b0;
    bias_m = 1'b0;
    repeat (3) begin
      check("abort_no_write", int'(wr_ena_o), 0);
      @(posedge clk_i); #1;
    end

    // Randomised cells on a random grid, with ready_i noise while busy.
    foreach (mem[i]) mem[i] = ($urandom_range(0, 9) < 4) ? 2'd0 : DW'($urandom_range(1, 3));
    for (int n = 0; n < 80; n++) begin
      if (n % 20 == 19)
        foreach (mem[i]) mem[i] = ($urandom_range(0, 9) < 4) ? 2'd0 : DW'($urandom_range(1, 3));
      b = int'($urandom_range(0, COLS*ROWS-1));
      run_cell(b, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
